hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Pipeline hazard and stall sequencer for the five-stage 32-bit core. Per cycle it decides which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) load, hold or take a bubble. The decision covers load-use hazards, taken-branch flushes and variable-latency data-memory accesses. It also contains a wait-state FSM with a timeout trap and saturating stall/flush event counters.

## Interface
Parameters:
- MAX_WAIT, 15: maximum consecutive memory-wait cycles before the trap fires (1..255).
- CNT_W, 16: width of each event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ID_EX_MemRead_Input  in  1  instruction in EX is a load.
- ID_EX_RegisterRt_Input  in  5  destination register of that load.
- IF_ID_RegisterRs_Input  in  5  rs of the instruction in ID.
- IF_ID_RegisterRt_Input  in  5  rt of the instruction in ID.
- IF_ID_UsesRt_Input  in  1  instruction in ID reads rt.
- EX_Branch_Taken_Input  in  1  branch/jump resolved taken in EX.
- EX_MEM_MemAccess_Input  in  1  instruction in MEM performs a load or store.
- Mem_Ready_Input  in  1  data memory completes the access this cycle.
- PC_Write_Output  out  1  PC loads next value.
- IF_ID_Write_Output  out  1  IF/ID loads.
- IF_ID_Flush_Output  out  1  IF/ID loads a NOP.
- ID_EX_Bubble_Output  out  1  ID/EX loads zeroed control signals.
- EX_MEM_Write_Output  out  1  EX/MEM loads.
- MEM_WB_Bubble_Output  out  1  MEM/WB loads zeroed control signals.
- Mem_Timeout_Output  out  1  sticky trap flag.
- Stall_Count_Output  out  CNT_W  saturating count of stall cycles.
- Flush_Count_Output  out  CNT_W  saturating count of branch flushes.

## Operation
- Conditions, evaluated combinationally each cycle:
  - mem_stall = EX_MEM_MemAccess_Input & ~Mem_Ready_Input.
  - lu_hazard = ID_EX_MemRead_Input & (ID_EX_RegisterRt_Input != 0) & ((ID_EX_RegisterRt_Input == IF_ID_RegisterRs_Input) | (IF_ID_UsesRt_Input & ID_EX_RegisterRt_Input == IF_ID_RegisterRt_Input)).
- Priority: TRAP > mem_stall > EX_Branch_Taken_Input > lu_hazard > normal.
- Normal: PC_Write, IF_ID_Write and EX_MEM_Write are 1. Flush and bubble outputs are 0.
- mem_stall:
  - PC_Write, IF_ID_Write and EX_MEM_Write are 0. ID/EX holds: Bubble=0, ID/EX has no write enable, so the hold is implicit from the frozen upstream.
  - MEM_WB_Bubble=1.
  - A concurrent branch or load-use condition is ignored. It is re-evaluated once the stall releases.
- Branch taken:
  - IF_ID_Flush=1 and ID_EX_Bubble=1; PC_Write=1 so the target is loaded.
  - Flush_Count increments.
  - A concurrent lu_hazard is ignored, since it belongs to the wrong path.
- lu_hazard:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - EX_MEM_Write=1 and MEM_WB_Bubble=0, so the load proceeds.
  - Exactly one bubble per hazard.
- Stall_Count increments in every mem_stall or lu_hazard cycle that takes effect. Both counters saturate at all-ones.
- FSM states:
  - RUN: if mem_stall, go to WAIT with wait_cnt=1.
  - WAIT: if ~mem_stall, go to RUN with wait_cnt=0. Else if wait_cnt==MAX_WAIT, go to TRAP. Else wait_cnt+1.
  - TRAP: absorbing. Mem_Timeout=1. PC_Write, IF_ID_Write and EX_MEM_Write are 0; MEM_WB_Bubble=1; all other outputs are 0. Counters freeze. Exit only by reset.
- wait_cnt is 8 bits, enough for MAX_WAIT up to 255.

## Timing
- Reset (asynchronous, immediate): state=RUN, wait_cnt=0, Mem_Timeout=0, both counters 0.
  - Outputs during reset: PC_Write=1, IF_ID_Write=1, EX_MEM_Write=1, all flush/bubble outputs 0.
- Control outputs are Mealy: combinational from the current inputs and state, with zero-cycle latency. They act at the next rising edge of the pipeline registers.
- The counters reflect an event one cycle after it occurs.
- Access with Mem_Ready high in its first MEM cycle: no stall.
- Access with Mem_Ready low for k cycles (k ≤ MAX_WAIT): exactly k stall cycles; the pipeline advances on cycle k+1.
- Mem_Ready still low after MAX_WAIT WAIT cycles: on the next edge the FSM enters TRAP. Mem_Timeout rises in cycle MAX_WAIT+2 counted from the first stalled cycle.
- Back-to-back accesses: RUN→WAIT→RUN→WAIT is legal. wait_cnt restarts at 1 for each new access.
- Reset asserted mid-WAIT or in TRAP returns to RUN immediately; no pending stall is remembered.

## Test plan
- Load r5 in EX, ID reads rs=r5 → one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; Stall_Count goes 0→1.
- Load to r0 with ID rs=r0 → no stall. Load rt=r7 while ID reads rt=r7 with UsesRt=0 → no stall.
- Branch taken with lu_hazard active in the same cycle → IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1; Flush_Count=1; Stall_Count unchanged.
- Store in MEM, Mem_Ready low for 3 cycles → 3 cycles with PC_Write=0, EX_MEM_Write=0, MEM_WB_Bubble=1; pipeline advances in cycle 4; Stall_Count=3; concurrent Branch_Taken is ignored until release.
- MAX_WAIT=4, Mem_Ready held low → Mem_Timeout=1 after 6 cycles; outputs stay frozen for 20 more cycles; asserting reset clears everything asynchronously.
- Force 2^CNT_W+5 stall cycles with CNT_W=4 → Stall_Count saturates at 15.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for the five-stage core: per-cycle load/hold/bubble
// decisions, a memory wait-state FSM with timeout trap, and saturating event counters.
module hazard_stall_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_MemRead_Input,
  input  logic [4:0]       ID_EX_RegisterRt_Input,
  input  logic [4:0]       IF_ID_RegisterRs_Input,
  input  logic [4:0]       IF_ID_RegisterRt_Input,
  input  logic             IF_ID_UsesRt_Input,
  input  logic             EX_Branch_Taken_Input,
  input  logic             EX_MEM_MemAccess_Input,
  input  logic             Mem_Ready_Input,
  output logic             PC_Write_Output,
  output logic             IF_ID_Write_Output,
  output logic             IF_ID_Flush_Output,
  output logic             ID_EX_Bubble_Output,
  output logic             EX_MEM_Write_Output,
  output logic             MEM_WB_Bubble_Output,
  output logic             Mem_Timeout_Output,
  output logic [CNT_W-1:0] Stall_Count_Output,
  output logic [CNT_W-1:0] Flush_Count_Output
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_TRAP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_stall, lu_hazard, rt_match_rs, rt_match_rt;
  logic stall_ev, flush_ev;

  assign mem_stall   = EX_MEM_MemAccess_Input & ~Mem_Ready_Input;
  assign rt_match_rs = (ID_EX_RegisterRt_Input == IF_ID_RegisterRs_Input);
  assign rt_match_rt = IF_ID_UsesRt_Input & (ID_EX_RegisterRt_Input == IF_ID_RegisterRt_Input);
  assign lu_hazard   = ID_EX_MemRead_Input & (ID_EX_RegisterRt_Input != 5'd0) &
                       (rt_match_rs | rt_match_rt);

  // Pipeline control, Mealy. While reset is held the pipe sees the
  // free-running pattern regardless of what the inputs are doing.
  always_comb begin
    PC_Write_Output      = 1'b1;
    IF_ID_Write_Output   = 1'b1;
    IF_ID_Flush_Output   = 1'b0;
    ID_EX_Bubble_Output  = 1'b0;
    EX_MEM_Write_Output  = 1'b1;
    MEM_WB_Bubble_Output = 1'b0;
    stall_ev             = 1'b0;
    flush_ev             = 1'b0;
    if (reset) begin
      stall_ev = 1'b0;
    end else if (state_q == S_TRAP) begin
      PC_Write_Output      = 1'b0;
      IF_ID_Write_Output   = 1'b0;
      EX_MEM_Write_Output  = 1'b0;
      MEM_WB_Bubble_Output = 1'b1;
    end else if (mem_stall) begin
      // ID/EX has no enable; freezing everything upstream holds it.
      PC_Write_Output      = 1'b0;
      IF_ID_Write_Output   = 1'b0;
      EX_MEM_Write_Output  = 1'b0;
      MEM_WB_Bubble_Output = 1'b1;
      stall_ev             = 1'b1;
    end else if (EX_Branch_Taken_Input) begin
      IF_ID_Flush_Output  = 1'b1;
      ID_EX_Bubble_Output = 1'b1;
      flush_ev            = 1'b1;
    end else if (lu_hazard) begin
      PC_Write_Output     = 1'b0;
      IF_ID_Write_Output  = 1'b0;
      ID_EX_Bubble_Output = 1'b1;
      stall_ev            = 1'b1;
    end
  end

  // Wait-state FSM: counts consecutive stalled MEM cycles.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d    = S_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      S_WAIT: begin
        if (!mem_stall) begin
          state_d    = S_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == 8'(MAX_WAIT)) begin
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_ev && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Mem_Timeout_Output = (state_q == S_TRAP);
  assign Stall_Count_Output = stall_cnt_q;
  assign Flush_Count_Output = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: stimulus pushes expected
// outputs from a rule-level model; a negedge monitor pops and compares.
module tb_hazard_stall_controller;
  localparam int MW  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mr, usesrt, br, acc, rdy;
  logic [4:0] exrt, rs, rt;
  logic pc_w, ifid_w, ifid_f, idex_b, exmem_w, mwb_b, tmo;
  logic [CW-1:0] scnt, fcnt;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_MemRead_Input(mr), .ID_EX_RegisterRt_Input(exrt),
    .IF_ID_RegisterRs_Input(rs), .IF_ID_RegisterRt_Input(rt),
    .IF_ID_UsesRt_Input(usesrt), .EX_Branch_Taken_Input(br),
    .EX_MEM_MemAccess_Input(acc), .Mem_Ready_Input(rdy),
    .PC_Write_Output(pc_w), .IF_ID_Write_Output(ifid_w),
    .IF_ID_Flush_Output(ifid_f), .ID_EX_Bubble_Output(idex_b),
    .EX_MEM_Write_Output(exmem_w), .MEM_WB_Bubble_Output(mwb_b),
    .Mem_Timeout_Output(tmo), .Stall_Count_Output(scnt),
    .Flush_Count_Output(fcnt)
  );

  typedef struct {
    int pc, ifid, flush, bub, exmem, mwb, to, sc, fc;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: sticky trap, length of the current stall run,
  // raw (unsaturated) event totals.
  bit m_trap;
  int m_run, m_stalls, m_flushes;

  task automatic chk(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      chk("pc_write",    pc_w,    e.pc);
      chk("ifid_write",  ifid_w,  e.ifid);
      chk("ifid_flush",  ifid_f,  e.flush);
      chk("idex_bubble", idex_b,  e.bub);
      chk("exmem_write", exmem_w, e.exmem);
      chk("memwb_bub",   mwb_b,   e.mwb);
      chk("timeout",     tmo,     e.to);
      chk("stall_count", int'(scnt), e.sc);
      chk("flush_count", int'(fcnt), e.fc);
    end
  end

  task automatic set_idle();
    mr = 0; exrt = 0; rs = 0; rt = 0; usesrt = 0; br = 0; acc = 0; rdy = 1;
  endtask

  task automatic step(input bit i_mr, input logic [4:0] i_exrt, input logic [4:0] i_rs,
                      input logic [4:0] i_rt, input bit i_use, input bit i_br,
                      input bit i_acc, input bit i_rdy);
    exp_t e;
    bit ms, lu;
    @(posedge clk); #1;
    mr = i_mr; exrt = i_exrt; rs = i_rs; rt = i_rt; usesrt = i_use;
    br = i_br; acc = i_acc; rdy = i_rdy;
    ms = i_acc && !i_rdy;
    lu = i_mr && (i_exrt != 0) && ((i_exrt == i_rs) || (i_use && i_exrt == i_rt));
    e.sc = sat(m_stalls); e.fc = sat(m_flushes); e.to = m_trap;
    e.pc = 1; e.ifid = 1; e.flush = 0; e.bub = 0; e.exmem = 1; e.mwb = 0;
    if (m_trap) begin
      e.pc = 0; e.ifid = 0; e.exmem = 0; e.mwb = 1;
    end else if (ms) begin
      e.pc = 0; e.ifid = 0; e.exmem = 0; e.mwb = 1; m_stalls++;
    end else if (i_br) begin
      e.flush = 1; e.bub = 1; m_flushes++;
    end else if (lu) begin
      e.pc = 0; e.ifid = 0; e.bub = 1; m_stalls++;
    end
    q.push_back(e);
    if (!m_trap) begin
      m_run = ms ? m_run + 1 : 0;
      if (m_run == MW + 1) m_trap = 1;
    end
  endtask

  // Async reset with hostile inputs: outputs must show the free-run pattern.
  task automatic do_reset();
    @(posedge clk); #1;
    acc = 1; rdy = 0; br = 1; mr = 1; exrt = 5; rs = 5;
    reset = 1;
    #2;
    chk("rst_pc_write",    pc_w,    1);
    chk("rst_ifid_write",  ifid_w,  1);
    chk("rst_exmem_write", exmem_w, 1);
    chk("rst_flush",       ifid_f,  0);
    chk("rst_bubble",      idex_b,  0);
    chk("rst_memwb_bub",   mwb_b,   0);
    chk("rst_timeout",     tmo,     0);
    chk("rst_stall_count", int'(scnt), 0);
    chk("rst_flush_count", int'(fcnt), 0);
    set_idle();
    m_trap = 0; m_run = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clk); #3;
    reset = 0;
  endtask

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'd7;
    endcase
  endfunction

  initial begin
    set_idle();
    m_trap = 0; m_run = 0; m_stalls = 0; m_flushes = 0;
    #12;
    do_reset();

    // load-use on rs, then r0 and unused-rt cases
    step(1, 5, 5, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0, 1);
    step(1, 7, 3, 7, 0, 0, 0, 1);
    step(1, 7, 3, 7, 1, 0, 0, 1);
    // branch wins over load-use
    step(1, 5, 5, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // 3-cycle memory wait with a pending branch, then release
    repeat (3) step(1, 5, 5, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // back-to-back accesses, each just under the limit
    repeat (MW) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (MW) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // timeout trap, then frozen with assorted inputs
    repeat (MW + 2) step(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (20) step(1, 5, 5, 5, 1, 1, $urandom_range(0, 1), 1);
    do_reset();

    // stall counter saturation: 2^CW+5 hazard cycles
    repeat (SAT + 6) step(1, 7, 1, 7, 1, 0, 0, 1);
    repeat (SAT + 3) step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();

    // randomized segments, alternating memory-ready bias
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 80; c++) begin
        step($urandom_range(0, 1), rnd_reg(), rnd_reg(), rnd_reg(),
             $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
             $urandom_range(0, 1),
             (s % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0));
      end
      do_reset();
    end

    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
